// File: rtl/fir_mac_sched.sv
// -----------------------------------------------------------------------------
// fir_mac_sched
// Time-shared FIR engine for the multi-band audio equalizer. A single
// multiplier-accumulator serves N_BANDS filters that share one circular delay
// line. Each accepted sample is written into the delay line, then N_TAPS MACs
// per band are sequenced against an external synchronous coefficient ROM.
// One saturated result per band is emitted, tagged with its band index.
//
// Ports
//   clk          clock
//   reset_n      synchronous active-low reset
//   data_in      signed input sample, qualified by in_valid
//   in_valid     data_in valid
//   in_ready     block can accept a sample (IDLE only)
//   flush        synchronous clear of the delay line, aborts any computation
//   coeff_addr   ROM address = band*N_TAPS + tap (0 when not reading)
//   coeff_rd_en  ROM read enable
//   coeff_data   ROM data, valid one cycle after coeff_addr/coeff_rd_en
//   data_out     signed filtered result, held between results
//   out_band     band index of data_out
//   out_valid    one-cycle result strobe
//   overrun      one-cycle pulse when a sample arrives while busy
// -----------------------------------------------------------------------------
module fir_mac_sched #(
    parameter int DATA_W  = 24,
    parameter int COEF_W  = 16,
    parameter int N_TAPS  = 61,
    parameter int N_BANDS = 3,
    localparam int ADDR_W = $clog2(N_BANDS * N_TAPS),
    localparam int BAND_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic        [ADDR_W-1:0] coeff_addr,
    output logic                     coeff_rd_en,
    input  logic signed [COEF_W-1:0] coeff_data,
    output logic signed [DATA_W-1:0] data_out,
    output logic        [BAND_W-1:0] out_band,
    output logic                     out_valid,
    output logic                     overrun
);

    localparam int TAP_W  = $clog2(N_TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    // Headroom of $clog2(N_TAPS) bits: a full band of MACs cannot overflow.
    localparam int ACC_W  = PROD_W + TAP_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t state, state_nxt;
    logic   accept;

    logic signed [DATA_W-1:0] dline [N_TAPS];
    logic        [TAP_W-1:0]  wr_ptr;
    logic        [TAP_W-1:0]  rd_ptr;
    logic        [TAP_W-1:0]  tap;
    logic        [BAND_W-1:0] band;
    logic        [ADDR_W-1:0] band_base;
    logic signed [ACC_W-1:0]  acc;

    logic signed [DATA_W-1:0] samp_p0;
    logic                     vld_p0;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;

    logic last_tap;
    logic last_band;

    // Q1.15 coefficients: drop COEF_W-1 fraction bits, then clamp to DATA_W.
    function automatic logic signed [DATA_W-1:0] sat_n(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> (COEF_W - 1);
        if (s > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
        else if (s < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        else                  return s[DATA_W-1:0];
    endfunction

    assign last_tap  = (tap == TAP_W'(N_TAPS - 1));
    assign last_band = (band == BAND_W'(N_BANDS - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || flush) state <= IDLE;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        coeff_rd_en = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                coeff_rd_en = 1'b1;
                if (last_tap) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                state_nxt = last_band ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
        // A flush cycle swallows in_valid silently.
        overrun = reset_n && in_valid && !flush && (state != IDLE);
    end

    assign coeff_addr = (state == ISSUE) ? (band_base + ADDR_W'(tap)) : '0;

    // Stage p0: sample registered alongside the ROM read it pairs with.
    always_ff @(posedge clk) begin
        samp_p0 <= dline[rd_ptr];
    end

    // Stage p1: MAC, using the coefficient returned for the previous issue.
    assign prod    = samp_p0 * coeff_data;
    assign acc_sum = acc + ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            for (int i = 0; i < N_TAPS; i++) dline[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tap       <= '0;
            band      <= '0;
            band_base <= '0;
            acc       <= '0;
            vld_p0    <= 1'b0;
        end else begin
            vld_p0 <= (state == ISSUE);
            if (vld_p0) acc <= acc_sum;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dline[wr_ptr] <= data_in;
                        rd_ptr        <= wr_ptr;
                        tap           <= '0;
                        band          <= '0;
                        band_base     <= '0;
                        acc           <= '0;
                    end
                end
                ISSUE: begin
                    tap    <= tap + TAP_W'(1);
                    // Walk backwards through history, wrapping 0 -> N_TAPS-1.
                    rd_ptr <= (rd_ptr == '0) ? TAP_W'(N_TAPS - 1) : rd_ptr - TAP_W'(1);
                end
                OUT: begin
                    acc    <= '0;
                    tap    <= '0;
                    rd_ptr <= wr_ptr;
                    if (!last_band) begin
                        band      <= band + BAND_W'(1);
                        band_base <= band_base + ADDR_W'(N_TAPS);
                    end else begin
                        // The newest sample becomes history only after every band used it.
                        wr_ptr <= (wr_ptr == TAP_W'(N_TAPS - 1)) ? '0 : wr_ptr + TAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p2: the result is captured at the end of DRAIN so it is stable
    // for the whole OUT cycle and held afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out <= '0;
            out_band <= '0;
        end else if (state == DRAIN && !flush) begin
            data_out <= sat_n(acc_sum);
            out_band <= band;
        end
    end

endmodule
